// File: rtl/fft_loader_if.sv
// fft_loader_if: sample stream in, radix-4 bank write port and FFT control handshake out.
interface fft_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              ready;
    logic              fft_rdy;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              start;
    modport master (output sample, valid, fft_rdy, input ready, we, addr, data, start);
    modport slave (input sample, valid, fft_rdy, output ready, we, addr, data, start);
endinterface

// File: rtl/fft_loader.sv
// fft_loader: stores one frame of samples into four radix-4 banks in base-4 digit-reversed order,
// then hands the frame to the FFT control and waits for it to be processed.
module fft_loader #(
    parameter int POINTS = 1024,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(POINTS) - 2
) (
    input logic         clk,
    input logic         rst,
    fft_loader_if.slave bus
);
    localparam int LOG2 = $clog2(POINTS);
    localparam int DIGITS = LOG2 / 2;
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
    state_t state, state_nx;
    logic [LOG2-1:0] n, r;
    logic acc;
    assign acc = bus.valid & bus.ready;
    always_comb begin
        r = '0;
        for (int i = 0; i < DIGITS; i++)
            r[2*i +: 2] = n[2*(DIGITS-1-i) +: 2];
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? LOAD :
                   state == LOAD  ? ((acc && &n) ? START : LOAD) :
                   state == START ? WAIT :
                   (bus.fft_rdy ? LOAD : WAIT);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    // ready mirrors the next state so it is high exactly while the FSM sits in LOAD
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            n <= '0;
            bus.ready <= 1'b0;
            bus.we <= 4'b0;
            bus.addr <= '0;
            bus.data <= '0;
            bus.start <= 1'b0;
        end else begin
            bus.ready <= state_nx == LOAD;
            bus.start <= state == START;
            bus.we <= acc ? 4'b1 << r[1:0] : 4'b0;
            if (acc) begin
                bus.addr <= r[LOG2-1:2];
                bus.data <= bus.sample;
                n <= n + 1'b1;
            end
        end
endmodule

// File: tb/tb_fft_loader.sv
// tb_fft_loader: directed checks of the 16-point loader: reset, write order, frame handshake, gaps, mid-frame reset.
module tb_fft_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fft_loader_if #(.DATA_W(16), .ADDR_W(2)) bus();
    fft_loader #(.POINTS(16), .DATA_W(16), .ADDR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int wn = 0;
    int starts = 0;
    int starts_before;
    logic [3:0]  wr_we   [32];
    logic [1:0]  wr_addr [32];
    logic [15:0] wr_data [32];
    // digit-reversed index for n = 4a+b is 4b+a
    logic [3:0] exp_r [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                               4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
    logic [3:0] e;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        if (bus.we != 4'b0 && wn < 32) begin
            wr_we[wn] = bus.we;
            wr_addr[wn] = bus.addr;
            wr_data[wn] = bus.data;
            wn++;
        end
        if (bus.start) starts++;
    end
    task automatic run_frame(input int gap_max, input logic [15:0] base);
        int t;
        logic [3:0] x;
        wn = 0;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bus.valid = 1'b0;
                tick;
            end
            bus.valid = 1'b1;
            bus.sample = base + 16'(k);
            t = 0;
            while (!bus.ready && t < 50) begin
                tick;
                t++;
            end
            if (t == 50) chk("ready_timeout", 0, 1);
            tick;
        end
        bus.valid = 1'b0;
        repeat (3) tick;
        chk("frame_write_count", wn, 16);
        for (int k = 0; k < 16; k++) begin
            x = exp_r[k];
            chk("frame_we", wr_we[k], 4'b1 << x[1:0]);
            chk("frame_addr", wr_addr[k], x[3:2]);
            chk("frame_data", wr_data[k], base + 16'(k));
        end
    endtask
    task automatic release_fft;
        bus.fft_rdy = 1'b1;
        tick;
        bus.fft_rdy = 1'b0;
        chk("ready_after_fft_rdy", bus.ready, 1);
    endtask
    initial begin
        bus.valid = 1'b0;
        bus.sample = '0;
        bus.fft_rdy = 1'b0;
        #2;
        chk("rst_ready", bus.ready, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_start", bus.start, 0);
        tick;
        tick;
        chk("rst_hold_ready", bus.ready, 0);
        rst = 1'b0;
        chk("ready_first_cycle", bus.ready, 0);
        tick;
        chk("ready_after_idle", bus.ready, 1);
        chk("we_idle", bus.we, 0);
        bus.fft_rdy = 1'b1;
        tick;
        bus.fft_rdy = 1'b0;
        chk("fft_rdy_ignored_load", bus.ready, 1);
        chk("we_no_valid", bus.we, 0);
        bus.valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.sample = 16'(k);
            tick;
            e = exp_r[k];
            chk("b2b_we", bus.we, 4'b1 << e[1:0]);
            chk("b2b_addr", bus.addr, e[3:2]);
            chk("b2b_data", bus.data, k);
            chk("b2b_ready", bus.ready, k < 15);
            chk("b2b_start", bus.start, 0);
        end
        tick;
        chk("start_pulse", bus.start, 1);
        chk("start_we", bus.we, 0);
        chk("start_ready", bus.ready, 0);
        tick;
        chk("start_single", bus.start, 0);
        chk("wait_ready", bus.ready, 0);
        repeat (3) begin
            tick;
            chk("wait_no_write", bus.we, 0);
        end
        chk("frame1_starts", starts, 1);
        bus.valid = 1'b0;
        tick;
        release_fft;
        run_frame(0, 16'h0100);
        chk("frame2_starts", starts, 2);
        release_fft;
        run_frame(3, 16'h0200);
        chk("frame3_starts", starts, 3);
        release_fft;
        run_frame(2, 16'h0300);
        chk("frame4_starts", starts, 4);
        release_fft;
        bus.valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.sample = 16'h0A00 + 16'(k);
            tick;
        end
        bus.valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.ready, 0);
        chk("midrst_we", bus.we, 0);
        chk("midrst_addr", bus.addr, 0);
        chk("midrst_data", bus.data, 0);
        chk("midrst_start", bus.start, 0);
        tick;
        rst = 1'b0;
        starts_before = starts;
        run_frame(1, 16'h0400);
        chk("post_rst_starts", starts, starts_before + 1);
        chk("post_rst_total_starts", starts, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
